// File: rtl/weight_ctrl_pkg.sv
// Shared definitions for the weight-path controllers: transfer state encoding and lane width.
package weight_ctrl_pkg;

   localparam int unsigned LANE_W = 8;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FETCH = 2'd1,
      DRAIN = 2'd2,
      DONE  = 2'd3
   } weight_state_e;

endpackage

// File: rtl/weight_skid_buf.sv
// One-entry holding register that parks a returned weight row while the FIFO is full.
module weight_skid_buf #(
   parameter int unsigned W = 128
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         flush,
   input  logic         load,
   input  logic         unload,
   input  logic [W-1:0] load_data,
   output logic         valid,
   output logic [W-1:0] data
);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         valid <= 1'b0;
         data  <= '0;
      end else begin
         if (flush)       valid <= 1'b0;
         else if (load)   valid <= 1'b1;
         else if (unload) valid <= 1'b0;
         if (load && !flush) data <= load_data;
      end
   end

endmodule

// File: rtl/weight_mem_fifo_control.sv
// Copies one weight sub-matrix from weight SRAM into the weight FIFO, last row first,
// masking unused columns and absorbing FIFO back-pressure with a one-entry skid buffer.
module weight_mem_fifo_control
   import weight_ctrl_pkg::*;
#(
   parameter int unsigned WIDTH_HEIGHT = 16,
   parameter int unsigned DATA_WIDTH   = WIDTH_HEIGHT * LANE_W,
   parameter int unsigned ADDR_WIDTH   = 8
) (
   input  logic                            clk,
   input  logic                            reset,
   input  logic                            en,
   input  logic [ADDR_WIDTH-1:0]           base_addr,
   input  logic [$clog2(WIDTH_HEIGHT)-1:0] num_row,
   input  logic [$clog2(WIDTH_HEIGHT)-1:0] num_col,
   output logic                            mem_rd_en,
   output logic [ADDR_WIDTH-1:0]           mem_addr,
   input  logic [DATA_WIDTH-1:0]           mem_rd_data,
   output logic                            fifo_wr_en,
   output logic [DATA_WIDTH-1:0]           fifo_wr_data,
   input  logic                            fifo_full,
   output logic                            done
);

   localparam int unsigned RW = $clog2(WIDTH_HEIGHT);
   localparam int unsigned CW = RW + 1;

   weight_state_e state_q, state_d;

   logic [RW-1:0]         num_row_q, num_col_q;
   logic [CW-1:0]         issued, written, written_nxt, row_cnt;
   logic                  rd_pending, skid_valid, skid_load, skid_unload;
   logic                  start, abort, last_issue, drain_done;
   logic [DATA_WIDTH-1:0] skid_data, ret_row, masked_row;

   assign row_cnt     = CW'(num_row_q) + CW'(1);
   assign start       = (state_q == IDLE) && en;
   assign abort       = ((state_q == FETCH) || (state_q == DRAIN)) && !en;

   // Never issue while a row is parked or the FIFO is full, so rd_pending and skid_valid stay exclusive.
   assign mem_rd_en   = (state_q == FETCH) && (issued <= CW'(num_row_q)) && !fifo_full && !skid_valid;
   assign last_issue  = mem_rd_en && (issued == CW'(num_row_q));

   assign skid_load   = rd_pending && fifo_full;
   assign skid_unload = skid_valid && !fifo_full;
   assign fifo_wr_en  = (rd_pending || skid_valid) && !fifo_full;
   assign written_nxt = written + CW'(fifo_wr_en);

   // Looks at this cycle's push so done rises the cycle after the last row leaves.
   assign drain_done  = (written_nxt == row_cnt) && !skid_load && !(skid_valid && fifo_full);

   assign ret_row     = skid_valid ? skid_data : mem_rd_data;

   for (genvar j = 0; j < WIDTH_HEIGHT; j++) begin : g_lane
      localparam logic [RW-1:0] LANE_IDX = RW'(j);
      assign masked_row[j*LANE_W +: LANE_W] =
         (LANE_IDX <= num_col_q) ? ret_row[j*LANE_W +: LANE_W] : '0;
   end

   assign fifo_wr_data = fifo_wr_en ? masked_row : '0;

   weight_skid_buf #(.W(DATA_WIDTH)) u_skid (
      .clk       (clk),
      .reset     (reset),
      .flush     (abort),
      .load      (skid_load),
      .unload    (skid_unload),
      .load_data (mem_rd_data),
      .valid     (skid_valid),
      .data      (skid_data)
   );

   // Next-state decode.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (en) state_d = FETCH;
         FETCH:   if (!en) state_d = IDLE;
                  else if (last_issue) state_d = DRAIN;
         DRAIN:   if (!en) state_d = IDLE;
                  else if (drain_done) state_d = DONE;
         DONE:    if (!en) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q    <= IDLE;
         done       <= 1'b0;
         rd_pending <= 1'b0;
         mem_addr   <= '0;
         issued     <= '0;
         written    <= '0;
         num_row_q  <= '0;
         num_col_q  <= '0;
      end else begin
         state_q    <= state_d;
         done       <= (state_d == DONE);
         rd_pending <= mem_rd_en && !abort;
         if (start) begin
            num_row_q <= num_row;
            num_col_q <= num_col;
            mem_addr  <= base_addr + ADDR_WIDTH'(num_row);
            issued    <= '0;
            written   <= '0;
         end else begin
            if (mem_rd_en) begin
               issued   <= issued + CW'(1);
               mem_addr <= mem_addr - ADDR_WIDTH'(1);
            end
            if (fifo_wr_en) written <= written_nxt;
         end
      end
   end

endmodule

// File: tb/tb_weight_mem_fifo_control.sv
// Scoreboard bench for weight_mem_fifo_control: behavioural SRAM, expected rows queued
// at stimulus time and compared against what the DUT pushes.
module tb_weight_mem_fifo_control;

   localparam int unsigned WH = 16;
   localparam int unsigned DW = WH * 8;
   localparam int unsigned AW = 8;

   logic          clk = 1'b0;
   logic          reset, en, fifo_full;
   logic [AW-1:0] base_addr, mem_addr;
   logic [3:0]    num_row, num_col;
   logic          mem_rd_en, fifo_wr_en, done;
   logic [DW-1:0] mem_rd_data, fifo_wr_data;

   int tests_run = 0;
   int tests_failed = 0;
   int edge_cnt = 0;
   int base = 0;
   bit mem_all_ff = 1'b0;

   logic [AW-1:0] exp_addr[$];
   logic [DW-1:0] exp_data[$];
   logic [AW-1:0] obs_addr[$];
   int            obs_rd_cyc[$];
   logic [DW-1:0] obs_data[$];
   int            obs_wr_cyc[$];
   logic          obs_wr_full[$];

   weight_mem_fifo_control #(.WIDTH_HEIGHT(WH), .DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
      .clk          (clk),
      .reset        (reset),
      .en           (en),
      .base_addr    (base_addr),
      .num_row      (num_row),
      .num_col      (num_col),
      .mem_rd_en    (mem_rd_en),
      .mem_addr     (mem_addr),
      .mem_rd_data  (mem_rd_data),
      .fifo_wr_en   (fifo_wr_en),
      .fifo_wr_data (fifo_wr_data),
      .fifo_full    (fifo_full),
      .done         (done)
   );

   always #5 clk = ~clk;

   always @(posedge clk) edge_cnt <= edge_cnt + 1;

   function automatic logic [DW-1:0] row_of(input logic [AW-1:0] a);
      logic [DW-1:0] r;
      for (int j = 0; j < int'(WH); j++)
         r[j*8 +: 8] = mem_all_ff ? 8'hFF : (a ^ 8'(j * 37 + 5));
      return r;
   endfunction

   function automatic logic [DW-1:0] exp_row(input logic [AW-1:0] a, input logic [3:0] nc);
      logic [DW-1:0] r;
      r = row_of(a);
      for (int j = 0; j < int'(WH); j++)
         if (j > int'(nc)) r[j*8 +: 8] = 8'h00;
      return r;
   endfunction

   // SRAM model: one-cycle read latency, junk data when not read.
   always @(posedge clk)
      mem_rd_data <= mem_rd_en ? row_of(mem_addr) : {(DW/16){16'hDEAD}};

   always @(negedge clk) begin
      if (fifo_wr_en) begin
         obs_data.push_back(fifo_wr_data);
         obs_wr_cyc.push_back(edge_cnt - base);
         obs_wr_full.push_back(fifo_full);
      end
      if (mem_rd_en) begin
         obs_addr.push_back(mem_addr);
         obs_rd_cyc.push_back(edge_cnt - base);
      end
   end

   // Caller must be at a negedge; en is sampled at the next posedge (edge 0).
   task automatic test_transfer(input string name, input logic [AW-1:0] ba, input logic [3:0] nr,
                                input logic [3:0] nc, input int stall_from, input int stall_to,
                                input int exp_done);
      int d0, a0, n, na, done_cyc;
      logic [DW-1:0] ed;
      logic [AW-1:0] ea;
      d0 = obs_data.size();
      a0 = obs_addr.size();
      for (int k = 0; k <= int'(nr); k++) begin
         ea = ba + 8'(nr) - 8'(k);
         exp_addr.push_back(ea);
         exp_data.push_back(exp_row(ea, nc));
      end
      base_addr = ba; num_row = nr; num_col = nc; fifo_full = 1'b0; en = 1'b1;
      base = edge_cnt;
      done_cyc = -1;
      for (int c = 1; c <= 200 && done_cyc < 0; c++) begin
         @(posedge clk); #1;
         fifo_full = (c >= stall_from) && (c <= stall_to);
         @(negedge clk);
         if (done) done_cyc = c;
      end
      fifo_full = 1'b0;
      #1;
      tests_run++;
      if (done_cyc !== exp_done) begin
         tests_failed++;
         $display("FAIL %s done_cycle: got %0d expected %0d", name, done_cyc, exp_done);
      end
      n = obs_data.size() - d0;
      tests_run++;
      if (n != int'(nr) + 1) begin
         tests_failed++;
         $display("FAIL %s push_count: got %0d expected %0d", name, n, int'(nr) + 1);
      end
      for (int i = 0; i < n; i++) begin
         tests_run++;
         if (exp_data.size() == 0) begin
            tests_failed++;
            $display("FAIL %s extra_push[%0d]: got %h expected none", name, i, obs_data[d0+i]);
         end else begin
            ed = exp_data.pop_front();
            if (obs_data[d0+i] !== ed || obs_wr_full[d0+i] !== 1'b0) begin
               tests_failed++;
               $display("FAIL %s push[%0d]: got %h full=%b expected %h full=0",
                        name, i, obs_data[d0+i], obs_wr_full[d0+i], ed);
            end
         end
      end
      na = obs_addr.size() - a0;
      for (int i = 0; i < na; i++) begin
         tests_run++;
         if (exp_addr.size() == 0) begin
            tests_failed++;
            $display("FAIL %s extra_read[%0d]: got %h expected none", name, i, obs_addr[a0+i]);
         end else begin
            ea = exp_addr.pop_front();
            if (obs_addr[a0+i] !== ea) begin
               tests_failed++;
               $display("FAIL %s read_addr[%0d]: got %h expected %h", name, i, obs_addr[a0+i], ea);
            end
         end
      end
      tests_run++;
      if (na != int'(nr) + 1 || n == 0 ||
          obs_rd_cyc[a0] !== 1 || obs_rd_cyc[a0+na-1] !== exp_done - 2 ||
          obs_wr_cyc[d0] !== 2 || obs_wr_cyc[d0+n-1] !== exp_done - 1) begin
         tests_failed++;
         $display("FAIL %s timing: reads=%0d pushes=%0d expected reads 1..%0d pushes 2..%0d",
                  name, na, n, exp_done - 2, exp_done - 1);
      end
      exp_data.delete();
      exp_addr.delete();
      en = 1'b0;
      @(posedge clk); #1;
      tests_run++;
      if (done !== 1'b0) begin
         tests_failed++;
         $display("FAIL %s done_drop: got %b expected 0", name, done);
      end
   endtask

   task automatic test_reset();
      reset = 1'b1; en = 1'b0; fifo_full = 1'b0;
      base_addr = '0; num_row = '0; num_col = '0;
      #2 reset = 1'b0;
      repeat (2) @(negedge clk);
      tests_run++;
      if ({mem_rd_en, fifo_wr_en, done} !== 3'b000 || mem_addr !== 8'h00 || fifo_wr_data !== '0) begin
         tests_failed++;
         $display("FAIL reset_state: got rd=%b wr=%b done=%b addr=%h data=%h expected all 0",
                  mem_rd_en, fifo_wr_en, done, mem_addr, fifo_wr_data);
      end
      reset = 1'b1;
      @(negedge clk);
      tests_run++;
      if ({mem_rd_en, fifo_wr_en, done} !== 3'b000) begin
         tests_failed++;
         $display("FAIL idle_no_en: got rd=%b wr=%b done=%b expected 000", mem_rd_en, fifo_wr_en, done);
      end
   endtask

   task automatic test_no_stall();
      @(negedge clk);
      mem_all_ff = 1'b0;
      test_transfer("no_stall", 8'h10, 4'd3, 4'd15, 1000, 0, 6);
   endtask

   task automatic test_col_mask();
      @(negedge clk);
      mem_all_ff = 1'b1;
      test_transfer("col_mask", 8'h50, 4'd3, 4'd2, 1000, 0, 6);
      mem_all_ff = 1'b0;
   endtask

   // Stall of 3 cycles plus one cycle spent draining the skid row before issue resumes.
   task automatic test_back_pressure();
      @(negedge clk);
      test_transfer("back_pressure", 8'h00, 4'd15, 4'd15, 4, 6, 22);
   endtask

   task automatic test_addr_wrap();
      @(negedge clk);
      test_transfer("addr_wrap", 8'hFE, 4'd3, 4'd15, 1000, 0, 6);
   endtask

   task automatic test_abort();
      int d0, n;
      bit done_seen, quiet;
      logic [DW-1:0] ed;
      @(negedge clk);
      d0 = obs_data.size();
      done_seen = 1'b0; quiet = 1'b1;
      base_addr = 8'h30; num_row = 4'd7; num_col = 4'd15; fifo_full = 1'b0; en = 1'b1;
      base = edge_cnt;
      for (int c = 1; c <= 12; c++) begin
         @(posedge clk); #1;
         if (c == 3) en = 1'b0;
         @(negedge clk);
         if (done) done_seen = 1'b1;
         if (c >= 4 && (mem_rd_en || fifo_wr_en)) quiet = 1'b0;
      end
      #1;
      tests_run++;
      if (done_seen !== 1'b0 || quiet !== 1'b1) begin
         tests_failed++;
         $display("FAIL abort_idle: got done_seen=%b quiet=%b expected 0 1", done_seen, quiet);
      end
      n = obs_data.size() - d0;
      tests_run++;
      if (n > 2) begin
         tests_failed++;
         $display("FAIL abort_push_count: got %0d expected at most 2", n);
      end
      for (int i = 0; i < n && i < 2; i++) begin
         ed = exp_row(8'h37 - 8'(i), 4'd15);
         tests_run++;
         if (obs_data[d0+i] !== ed) begin
            tests_failed++;
            $display("FAIL abort_push[%0d]: got %h expected %h", i, obs_data[d0+i], ed);
         end
      end
      @(negedge clk);
      test_transfer("abort_restart", 8'h20, 4'd5, 4'd7, 1000, 0, 8);
   endtask

   task automatic test_reset_drain();
      @(negedge clk);
      base_addr = 8'h40; num_row = 4'd0; num_col = 4'd15; fifo_full = 1'b0; en = 1'b1;
      base = edge_cnt;
      @(posedge clk); #1; fifo_full = 1'b0;
      @(posedge clk); #1; fifo_full = 1'b1;
      @(posedge clk); #1;
      tests_run++;
      if (fifo_wr_en !== 1'b0 || done !== 1'b0) begin
         tests_failed++;
         $display("FAIL skid_hold: got wr=%b done=%b expected 0 0", fifo_wr_en, done);
      end
      reset = 1'b0;
      #1;
      tests_run++;
      if ({mem_rd_en, fifo_wr_en, done} !== 3'b000 || mem_addr !== 8'h00 || fifo_wr_data !== '0) begin
         tests_failed++;
         $display("FAIL async_reset: got rd=%b wr=%b done=%b addr=%h data=%h expected all 0",
                  mem_rd_en, fifo_wr_en, done, mem_addr, fifo_wr_data);
      end
      fifo_full = 1'b0;
      @(negedge clk);
      tests_run++;
      if (fifo_wr_en !== 1'b0) begin
         tests_failed++;
         $display("FAIL reset_no_push: got %b expected 0", fifo_wr_en);
      end
      reset = 1'b1;
      test_transfer("reset_restart", 8'h80, 4'd2, 4'd15, 1000, 0, 5);
   endtask

   initial begin
      test_reset();
      test_no_stall();
      test_col_mask();
      test_back_pressure();
      test_addr_wrap();
      test_abort();
      test_reset_drain();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

endmodule
